// File: rtl/reg_fifo_if.sv
// reg_fifo_if: producer/consumer bundle for reg_fifo.
//   master : push/pop/clear requests out, data and status in (bench or host logic)
//   slave  : the FIFO itself
//   WIDTH  : data word width
//   DEPTH  : FIFO depth; sets the width of count
interface reg_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] write_data;
    logic             write_enable;
    logic             read_enable;
    logic             clr_err;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_data, write_enable, read_enable, clr_err,
        input  read_data, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  write_data, write_enable, read_enable, clr_err,
        output read_data, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/reg_fifo.sv
// reg_fifo: register-bank FIFO with circular pointers, occupancy counter,
// full/empty/almost-full status and sticky overflow/underflow flags.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears pointers, count, storage, flags
//   bus   : reg_fifo_if.slave
//           write_data/write_enable push, read_enable pop, clr_err clears flags;
//           read_data is the show-ahead head word (0 when empty);
//           empty/full/almost_full/count decode the occupancy register;
//           overflow/underflow are sticky rejected-request flags.
module reg_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic         clk,
    input  logic         reset,
    reg_fifo_if.slave    bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              empty_c;
    logic              full_c;
    logic              push_ok;
    logic              pop_ok;
    logic              push_rej;
    logic              pop_rej;
    logic [DEPTH-1:0]  word_load;

    // Occupancy decodes
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // Acceptance: a pop in the same cycle frees the slot for a push when full
    assign pop_ok   = bus.read_enable && !empty_c;
    assign push_ok  = bus.write_enable && (!full_c || bus.read_enable);
    assign push_rej = bus.write_enable && !push_ok;
    assign pop_rej  = bus.read_enable && !pop_ok;

    // Write-address decoder: one load enable per storage word
    always_comb begin
        word_load = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push_ok && (wr_ptr == ADDR_W'(i))) begin
                word_load[i] = 1'b1;
            end
        end
    end

    // Storage bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (word_load[i]) begin
                    mem[i] <= bus.write_data;
                end
            end
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_rej) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (pop_rej) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Show-ahead head word, forced to zero when empty
    assign bus.read_data   = empty_c ? '0 : mem[rd_ptr];
    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.almost_full = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: directed scoreboard bench for reg_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3).
module tb_reg_fifo;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [WIDTH-1:0] sb [$];
    logic             m_ovf;
    logic             m_unf;

    reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every status output against the scoreboard state
    task automatic check_state(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, ".count"},       32'(bus.count),       32'(sb.size()));
        chk({tag, ".empty"},       32'(bus.empty),       32'(sb.size() == 0));
        chk({tag, ".full"},        32'(bus.full),        32'(sb.size() == DEPTH));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(sb.size() >= AF));
        chk({tag, ".read_data"},   32'(bus.read_data),   32'(head));
        chk({tag, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
        chk({tag, ".underflow"},   32'(bus.underflow),   32'(m_unf));
    endtask

    // One clock of stimulus; called just after a rising edge
    task automatic step(input string tag, input logic we, input logic [WIDTH-1:0] wd,
                        input logic re, input logic clr);
        logic push_ok;
        logic pop_ok;
        logic [WIDTH-1:0] popped;
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        bus.clr_err      = clr;
        #1;
        pop_ok  = re && (sb.size() > 0);
        push_ok = we && ((sb.size() < DEPTH) || re);
        if (pop_ok) begin
            popped = sb.pop_front();
            chk({tag, ".pop_data"}, 32'(bus.read_data), 32'(popped));
        end
        if (push_ok) sb.push_back(wd);
        if (we && !push_ok) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (re && !pop_ok)  m_unf = 1'b1;
        else if (clr)       m_unf = 1'b0;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.clr_err      = 1'b0;
        check_state(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        reset  = 1'b0;
        bus.write_data   = '0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.clr_err      = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b1;
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full
        step("push11", 1'b1, 8'h11, 1'b0, 1'b0);
        step("push22", 1'b1, 8'h22, 1'b0, 1'b0);
        step("push33", 1'b1, 8'h33, 1'b0, 1'b0);
        chk("af_after_3", 32'(bus.almost_full), 32'd1);
        step("push44", 1'b1, 8'h44, 1'b0, 1'b0);
        chk("full_after_4", 32'(bus.full), 32'd1);
        chk("head_11", 32'(bus.read_data), 32'h11);

        // Rejected push when full
        step("push55_full", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);

        // Drain
        step("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop4", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drained_rd", 32'(bus.read_data), 32'h00);

        // Pointer wrap with simultaneous push/pop
        step("wrap_A0", 1'b1, 8'hA0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            step("wrap_pp", 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        end
        chk("wrap_count", 32'(bus.count), 32'd1);
        step("wrap_last", 1'b0, 8'h00, 1'b1, 1'b0);

        // Full with push and pop together
        step("refill11", 1'b1, 8'h11, 1'b0, 1'b0);
        step("refill22", 1'b1, 8'h22, 1'b0, 1'b0);
        step("refill33", 1'b1, 8'h33, 1'b0, 1'b0);
        step("refill44", 1'b1, 8'h44, 1'b0, 1'b0);
        step("full_pp66", 1'b1, 8'h66, 1'b1, 1'b0);
        chk("full_pp_count", 32'(bus.count), 32'd4);

        // Clear coinciding with a new overflow keeps the flag
        step("clr_vs_ovf", 1'b1, 8'h88, 1'b0, 1'b1);
        chk("ovf_kept", 32'(bus.overflow), 32'd1);
        step("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        step("pop22", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop33", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop44", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop66", 1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with push and pop together
        step("empty_pp77", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_pp_rd", 32'(bus.read_data), 32'h77);
        chk("unf_set", 32'(bus.underflow), 32'd1);
        step("pop77", 1'b0, 8'h00, 1'b1, 1'b0);
        step("underflow_again", 1'b0, 8'h00, 1'b1, 1'b0);
        step("push_ovf_bait", 1'b1, 8'h01, 1'b0, 1'b0);
        step("pop_bait", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_both", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_cleared", 32'(bus.underflow), 32'd0);

        // Asynchronous reset mid-operation
        step("hold1", 1'b1, 8'h01, 1'b0, 1'b0);
        step("hold2", 1'b1, 8'h02, 1'b0, 1'b0);
        step("hold3", 1'b1, 8'h03, 1'b0, 1'b0);
        step("ovf_before_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        step("hold3b", 1'b1, 8'h03, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state("async_rst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("push99", 1'b1, 8'h99, 1'b0, 1'b0);
        chk("post_rst_rd", 32'(bus.read_data), 32'h99);
        chk("post_rst_cnt", 32'(bus.count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
